// File: rtl/latch_write_ctrl.sv
// latch_write_ctrl: sequences a single write into a level-sensitive latch bank.
// Each write runs through SETUP (data settles), PULSE (gate open) and HOLD
// (data held after gate closes). When HOLD ends, the controller reads the
// latch outputs back and reports whether they match the driven word.
module latch_write_ctrl #(
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Valid,
    input  logic [WIDTH-1:0] Data,
    output logic             Ready,
    output logic             Enable,
    output logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] Q,
    output logic             Done,
    output logic             Error
);

    // Phase lengths stored as "cycles minus one" so the counter
    // expires when it reaches zero.
    localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYC - 1);
    localparam logic [3:0] HOLD_LOAD  = 4'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t           state_q,  state_d;
    logic [3:0]       cnt_q,    cnt_d;
    logic [WIDTH-1:0] d_q,      d_d;
    logic             enable_q, enable_d;
    logic             ready_q,  ready_d;
    logic             done_q,   done_d;
    logic             error_q,  error_d;

    // Readback comparison between the latch outputs and the driven word.
    function automatic logic word_mismatch(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
        return (a != b);
    endfunction

    // Next-state, phase counter and output computation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        d_d      = d_q;
        error_d  = error_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Valid) begin
                    d_d     = Data;
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LOAD;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_PULSE;
                    cnt_d   = PULSE_LOAD;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                    done_d  = 1'b1;
                    // Q is sampled on the same edge that leaves HOLD.
                    error_d = word_mismatch(Q, d_q);
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Outputs are registered from the next state so each one lines up
        // with the state it describes and comes straight off a flop.
        enable_d = (state_d == ST_PULSE);
        ready_d  = (state_d == ST_IDLE);
    end

    // State, counter and registered outputs; reset clears everything at once
    // so Enable drops without waiting for a clock edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            d_q      <= '0;
            enable_q <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            d_q      <= d_d;
            enable_q <= enable_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign Ready  = ready_q;
    assign Enable = enable_q;
    assign D      = d_q;
    assign Done   = done_q;
    assign Error  = error_q;

endmodule
